// File: rtl/pe_pkg.sv
// Shared constants and types for the Rice-decoder leading-one priority encoder.
package pe_pkg;

   localparam int PE_WIDTH = 32;
   localparam int PE_LW    = 5;

   typedef logic [PE_LW-1:0] pe_idx_t;

endpackage

// File: rtl/pencoder_msb_lod_node.sv
// Leading-one-detect tree node: merges an upper and a lower child (valid, index)
// pair into the parent pair one level up the tree.
module lod_node #(
   parameter int LW    = 5,
   parameter int LEVEL = 0
) (
   input  logic          i_hi_v,
   input  logic [LW-1:0] i_hi_idx,
   input  logic          i_lo_v,
   input  logic [LW-1:0] i_lo_idx,
   output logic          o_v,
   output logic [LW-1:0] o_idx
);

   // Child indices only carry bits below LEVEL; the upper half wins whenever
   // it holds a one, and that choice becomes index bit LEVEL.
   always_comb begin
      o_idx        = i_hi_v ? i_hi_idx : i_lo_idx;
      o_idx[LEVEL] = i_hi_v;
      o_v          = i_hi_v | i_lo_v;
   end

endmodule

// File: rtl/pencoder_msb.sv
// Registered 32-bit leading-one priority encoder: bit index of the highest set
// bit, the leading-zero count above it, and an all-zero flag, one cycle later.
module pencoder_msb
   import pe_pkg::*;
#(
   parameter int WIDTH = PE_WIDTH,
   parameter int LW    = PE_LW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             peen,
   input  logic [WIDTH-1:0] in,
   output logic [LW-1:0]    out,
   output logic [LW-1:0]    len,
   output logic             zero
);

   localparam logic [LW-1:0] MAX_IDX = LW'(WIDTH - 1);

   // Heap-ordered tree: node n has upper child 2n and lower child 2n+1; slots
   // WIDTH..2*WIDTH-1 are the input bits, MSB first, and node 1 is the root.
   logic          w_v   [1:2*WIDTH-1];
   logic [LW-1:0] w_idx [1:2*WIDTH-1];

   logic [LW-1:0] r_out;
   logic [LW-1:0] r_len;
   logic          r_zero;

   genvar k, j;
   generate
      for (k = 0; k < WIDTH; k++) begin : g_leaf
         assign w_v[WIDTH+k]   = in[WIDTH-1-k];
         assign w_idx[WIDTH+k] = '0;
      end

      for (j = 0; j < LW; j++) begin : g_lvl
         for (k = 0; k < (1 << j); k++) begin : g_node
            lod_node #(
               .LW    (LW),
               .LEVEL (LW - 1 - j)
            ) u_node (
               .i_hi_v   (w_v[2*((1 << j) + k)]),
               .i_hi_idx (w_idx[2*((1 << j) + k)]),
               .i_lo_v   (w_v[2*((1 << j) + k) + 1]),
               .i_lo_idx (w_idx[2*((1 << j) + k) + 1]),
               .o_v      (w_v[(1 << j) + k]),
               .o_idx    (w_idx[(1 << j) + k])
            );
         end
      end
   endgenerate

   // An all-zero word leaves the root index at 0, so len saturates at WIDTH-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out  <= '0;
         r_len  <= '0;
         r_zero <= 1'b0;
      end else if (peen) begin
         r_out  <= w_idx[1];
         r_len  <= MAX_IDX - w_idx[1];
         r_zero <= ~w_v[1];
      end
   end

   assign out  = r_out;
   assign len  = r_len;
   assign zero = r_zero;

endmodule

// File: tb/tb_pencoder_msb.sv
// Randomised scoreboard bench for pencoder_msb against a count-leading-zeros model.
module tb_pencoder_msb;
   import pe_pkg::*;

   localparam int W = PE_WIDTH;

   logic          clk;
   logic          reset;
   logic          peen;
   logic [W-1:0]  in;
   pe_idx_t       out;
   pe_idx_t       len;
   logic          zero;

   logic [2*PE_LW:0] exp_q[$];

   int n_checks;
   int n_fail;

   pe_idx_t m_out;
   pe_idx_t m_len;
   logic    m_zero;

   pencoder_msb dut (
      .clk   (clk),
      .reset (reset),
      .peen  (peen),
      .in    (in),
      .out   (out),
      .len   (len),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: position of the highest one found by repeated halving.
   function automatic int msb_pos(input logic [W-1:0] x);
      int p;
      logic [W-1:0] v;
      p = 0;
      v = x;
      while (v > 1) begin
         v = v >> 1;
         p++;
      end
      return p;
   endfunction

   task automatic cycle(input logic r, input logic p, input logic [W-1:0] d);
      reset = r;
      peen  = p;
      in    = d;
      @(posedge clk);
      if (!r) begin
         m_out = '0; m_len = '0; m_zero = 1'b0;
      end else if (p) begin
         if (d == '0) begin
            m_out = '0; m_len = pe_idx_t'(W - 1); m_zero = 1'b1;
         end else begin
            m_out  = pe_idx_t'(msb_pos(d));
            m_len  = pe_idx_t'(W - 1 - msb_pos(d));
            m_zero = 1'b0;
         end
      end
      exp_q.push_back({m_zero, m_len, m_out});
      #1;
   endtask

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: results are registered, so each sampling edge's expectation is
   // compared on the following falling edge.
   always @(negedge clk) begin
      logic [2*PE_LW:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if ($isunknown({zero, len, out})) begin
            n_fail++;
            $display("FAIL unknown_out: got out=%b len=%b zero=%b at %0t", out, len, zero, $time);
         end else begin
            n_checks = n_checks - 1;
            check("out",  int'(out),  int'(e[PE_LW-1:0]));
            check("len",  int'(len),  int'(e[2*PE_LW-1:PE_LW]));
            check("zero", int'(zero), int'(e[2*PE_LW]));
         end
      end
   end

   initial begin
      logic [W-1:0] d;
      int wait_cnt;
      n_checks = 0;
      n_fail   = 0;
      m_out = '0; m_len = '0; m_zero = 1'b0;
      reset = 1'b0; peen = 1'b0; in = '0;

      cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b1, 32'b0000_1010_0001_0000_1000_0010_1000_0001);
      cycle(1'b1, 1'b1, 32'h8A10_8281);
      cycle(1'b1, 1'b1, 32'h4A10_8281);
      cycle(1'b1, 1'b1, 32'h0000_0001);
      cycle(1'b1, 1'b1, 32'h0000_0000);
      cycle(1'b1, 1'b1, 32'h0010_0000);
      repeat (3) cycle(1'b1, 1'b0, 32'h8000_0000);
      cycle(1'b1, 1'b1, 32'h8000_0000);

      for (int i = 0; i < 1000; i++) begin
         d = $urandom();
         d = d >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) d = '0;
         cycle(1'b1, 1'($urandom_range(0, 1)), d);
      end

      cycle(1'b1, 1'b1, 32'h0000_0400);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'($urandom_range(0, 1)), $urandom());
      cycle(1'b1, 1'b0, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b1, 32'h0000_0003);
      cycle(1'b1, 1'b1, 32'h0000_0003);

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
